// File: rtl/clint_mmio_timer.sv
// ---------------------------------------------------------------------------
// clint_mmio_timer
//
// Machine timer and interrupt responder on the CPU data-memory/MMIO port.
// It sits beside the data RAM and decodes CPU stores and loads that fall in
// its 32-byte register window. Loads are answered one cycle later, with the
// same latency as the BRAM. The block also drives the CPU's mtime and
// interrupt inputs.
//
// Register map (offsets from BASE_ADDR, word aligned, addr[1:0] ignored):
//   0x00 MSIP           bit0 read/write, other bits read as zero
//   0x08 MTIMECMP_LO
//   0x0C MTIMECMP_HI
//   0x10 MTIME_LO       a load here also snapshots mtime[63:32]
//   0x14 MTIME_HI
//   0x18 MTIME_HI_SNAP  read-only, upper half captured by the last MTIME_LO load
//   others              read as zero, writes ignored
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_data_mem_addr              CPU store byte address
//   i_data_mem_wr_data           CPU store data
//   i_data_mem_per_byte_wr_en    CPU per-byte store enables
//   i_mmio_read_pulse            one-cycle MMIO load strobe
//   i_mmio_load_addr             MMIO load byte address
//   i_ext_irq                    level external interrupt request
//   o_mmio_rd_data               load data, valid the cycle after the strobe
//   o_mmio_rd_valid              high for one cycle on in-window load responses
//   o_mtime                      current mtime, taken straight from the register
//   o_interrupts                 {meip, mtip, msip}, registered
// ---------------------------------------------------------------------------
module clint_mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [63:0] CMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_data_mem_addr,
    input  logic [31:0] i_data_mem_wr_data,
    input  logic [3:0]  i_data_mem_per_byte_wr_en,
    input  logic        i_mmio_read_pulse,
    input  logic [31:0] i_mmio_load_addr,
    input  logic        i_ext_irq,
    output logic [31:0] o_mmio_rd_data,
    output logic        o_mmio_rd_valid,
    output logic [63:0] o_mtime,
    output logic [2:0]  o_interrupts
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    localparam logic [2:0] IDX_MSIP      = 3'd0;
    localparam logic [2:0] IDX_CMP_LO    = 3'd2;
    localparam logic [2:0] IDX_CMP_HI    = 3'd3;
    localparam logic [2:0] IDX_MTIME_LO  = 3'd4;
    localparam logic [2:0] IDX_MTIME_HI  = 3'd5;
    localparam logic [2:0] IDX_SNAP      = 3'd6;

    logic [63:0]     mtime_q,     mtime_d;
    logic [63:0]     mtimeCmp_q,  mtimeCmp_d;
    logic            msip_q,      msip_d;
    logic [PS_W-1:0] prescaler_q, prescaler_d;
    logic [31:0]     snapHi_q,    snapHi_d;
    logic [31:0]     rdData_q,    rdData_d;
    logic            rdValid_q,   rdValid_d;
    logic [2:0]      irq_q,       irq_d;

    logic        wrHit;
    logic [2:0]  wrIdx;
    logic        rdHit;
    logic [2:0]  rdIdx;
    logic        tick;
    logic        loWrite;
    logic        hiWrite;
    logic        loCarry;
    logic [31:0] loTicked;
    logic [31:0] hiTicked;
    logic [31:0] rdMux;
    logic        unusedAddrBits;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  byteEn);
        logic [31:0] res;
        res = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) begin
                res[8*b +: 8] = newVal[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign unusedAddrBits = ^{i_data_mem_addr[1:0], i_mmio_load_addr[1:0]};

    assign wrHit = (i_data_mem_addr[31:5] == BASE_ADDR[31:5]) && (i_data_mem_per_byte_wr_en != 4'b0000);
    assign wrIdx = i_data_mem_addr[4:2];
    assign rdHit = i_mmio_read_pulse && (i_mmio_load_addr[31:5] == BASE_ADDR[31:5]);
    assign rdIdx = i_mmio_load_addr[4:2];
    assign tick  = (prescaler_q == PS_LAST);

    // Read mux sees the registers as they are before this edge's updates,
    // so a store and load to the same register in one cycle returns the old value.
    always_comb begin
        rdMux = 32'h0;
        case (rdIdx)
            IDX_MSIP:     rdMux = {31'h0, msip_q};
            IDX_CMP_LO:   rdMux = mtimeCmp_q[31:0];
            IDX_CMP_HI:   rdMux = mtimeCmp_q[63:32];
            IDX_MTIME_LO: rdMux = mtime_q[31:0];
            IDX_MTIME_HI: rdMux = mtime_q[63:32];
            IDX_SNAP:     rdMux = snapHi_q;
            default:      rdMux = 32'h0;
        endcase
    end

    // Next-state logic. mtime is split in halves so that a store to the low
    // word can suppress the carry into the high word while the unwritten half
    // still follows the tick.
    always_comb begin
        prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);

        loWrite  = wrHit && (wrIdx == IDX_MTIME_LO);
        hiWrite  = wrHit && (wrIdx == IDX_MTIME_HI);
        loTicked = mtime_q[31:0] + {31'h0, tick};
        loCarry  = tick && (&mtime_q[31:0]) && !loWrite;
        hiTicked = mtime_q[63:32] + {31'h0, loCarry};

        mtime_d[31:0]  = loWrite ? mergeBytes(loTicked, i_data_mem_wr_data, i_data_mem_per_byte_wr_en) : loTicked;
        mtime_d[63:32] = hiWrite ? mergeBytes(hiTicked, i_data_mem_wr_data, i_data_mem_per_byte_wr_en) : hiTicked;

        mtimeCmp_d = mtimeCmp_q;
        if (wrHit && (wrIdx == IDX_CMP_LO)) begin
            mtimeCmp_d[31:0] = mergeBytes(mtimeCmp_q[31:0], i_data_mem_wr_data, i_data_mem_per_byte_wr_en);
        end
        if (wrHit && (wrIdx == IDX_CMP_HI)) begin
            mtimeCmp_d[63:32] = mergeBytes(mtimeCmp_q[63:32], i_data_mem_wr_data, i_data_mem_per_byte_wr_en);
        end

        msip_d = msip_q;
        if (wrHit && (wrIdx == IDX_MSIP) && i_data_mem_per_byte_wr_en[0]) begin
            msip_d = i_data_mem_wr_data[0];
        end

        snapHi_d = snapHi_q;
        if (rdHit && (rdIdx == IDX_MTIME_LO)) begin
            snapHi_d = mtime_q[63:32];
        end

        rdValid_d = rdHit;
        rdData_d  = rdHit ? rdMux : 32'h0;

        irq_d = {i_ext_irq, (mtime_q >= mtimeCmp_q), msip_q};
    end

    // State registers with synchronous reset; reset also drops any read
    // response that would have been produced by a strobe in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime_q     <= 64'h0;
            mtimeCmp_q  <= CMP_RST;
            msip_q      <= 1'b0;
            prescaler_q <= '0;
            snapHi_q    <= 32'h0;
            rdData_q    <= 32'h0;
            rdValid_q   <= 1'b0;
            irq_q       <= 3'b000;
        end else begin
            mtime_q     <= mtime_d;
            mtimeCmp_q  <= mtimeCmp_d;
            msip_q      <= msip_d;
            prescaler_q <= prescaler_d;
            snapHi_q    <= snapHi_d;
            rdData_q    <= rdData_d;
            rdValid_q   <= rdValid_d;
            irq_q       <= irq_d;
        end
    end

    assign o_mtime         = mtime_q;
    assign o_mmio_rd_data  = rdData_q;
    assign o_mmio_rd_valid = rdValid_q;
    assign o_interrupts    = irq_q;

endmodule

// File: tb/tb_clint_mmio_timer.sv
// ---------------------------------------------------------------------------
// tb_clint_mmio_timer
//
// Drives two instances of the timer, one with TICK_DIV=1 and one with
// TICK_DIV=4, from the same stimulus. A reference model built from the
// register-map rules predicts mtime, the interrupts, and the load responses.
// Load responses are queued by the driver and checked by an independent
// monitor process.
// ---------------------------------------------------------------------------
module tb_clint_mmio_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wAddr;
    logic [31:0] wData;
    logic [3:0]  wBe;
    logic        rdPulse;
    logic [31:0] rAddr;
    logic        extIrq;

    logic [31:0] rdData1,  rdData4;
    logic        rdValid1, rdValid4;
    logic [63:0] mtime1,   mtime4;
    logic [2:0]  irq1,     irq4;

    int nCompared = 0;
    int nFailed   = 0;
    bit monitorOn = 1'b0;

    // Expected load responses {valid, data}, one entry per strobe.
    logic [32:0] expQ0[$];
    logic [32:0] expQ1[$];

    // Reference model state, index 0 -> TICK_DIV=1, index 1 -> TICK_DIV=4.
    int          divOf[2] = '{1, 4};
    logic [63:0] mMtime[2];
    logic [63:0] mCmp[2];
    logic        mMsip[2];
    int          mPre[2];
    logic [31:0] mSnap[2];
    logic [2:0]  mIrq[2];
    logic [63:0] nMtime[2];
    logic [63:0] nCmp[2];
    logic        nMsip[2];
    int          nPre[2];
    logic [31:0] nSnap[2];
    logic [2:0]  nIrq[2];

    always #5 clk = ~clk;

    clint_mmio_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_data_mem_addr(wAddr), .i_data_mem_wr_data(wData), .i_data_mem_per_byte_wr_en(wBe),
        .i_mmio_read_pulse(rdPulse), .i_mmio_load_addr(rAddr), .i_ext_irq(extIrq),
        .o_mmio_rd_data(rdData1), .o_mmio_rd_valid(rdValid1),
        .o_mtime(mtime1), .o_interrupts(irq1)
    );

    clint_mmio_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_data_mem_addr(wAddr), .i_data_mem_wr_data(wData), .i_data_mem_per_byte_wr_en(wBe),
        .i_mmio_read_pulse(rdPulse), .i_mmio_load_addr(rAddr), .i_ext_irq(extIrq),
        .o_mmio_rd_data(rdData4), .o_mmio_rd_valid(rdValid4),
        .o_mtime(mtime4), .o_interrupts(irq4)
    );

    task automatic compare(input string name, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldV, input logic [31:0] newV,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = oldV;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = newV[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] regValue(input int k, input logic [2:0] idx);
        case (idx)
            3'd0:    return {31'h0, mMsip[k]};
            3'd2:    return mCmp[k][31:0];
            3'd3:    return mCmp[k][63:32];
            3'd4:    return mMtime[k][31:0];
            3'd5:    return mMtime[k][63:32];
            3'd6:    return mSnap[k];
            default: return 32'h0;
        endcase
    endfunction

    // One clock of the reference model for instance k, from the current inputs.
    task automatic modelStep(input int k);
        logic [63:0] t;
        logic [32:0] exp;
        logic        tk;
        exp = 33'h0;
        if (rst) begin
            nMtime[k] = 64'h0;
            nCmp[k]   = 64'hFFFF_FFFF_FFFF_FFFF;
            nMsip[k]  = 1'b0;
            nPre[k]   = 0;
            nSnap[k]  = 32'h0;
            nIrq[k]   = 3'b000;
        end else begin
            nIrq[k]  = {extIrq, (mMtime[k] >= mCmp[k]), mMsip[k]};
            nSnap[k] = mSnap[k];
            nCmp[k]  = mCmp[k];
            nMsip[k] = mMsip[k];
            if (rdPulse && (rAddr[31:5] == BASE[31:5])) begin
                exp = {1'b1, regValue(k, rAddr[4:2])};
                if (rAddr[4:2] == 3'd4) nSnap[k] = mMtime[k][63:32];
            end
            tk      = (mPre[k] == divOf[k] - 1);
            nPre[k] = tk ? 0 : mPre[k] + 1;
            t       = mMtime[k] + (tk ? 64'd1 : 64'd0);
            if ((wAddr[31:5] == BASE[31:5]) && (wBe != 4'b0000)) begin
                case (wAddr[4:2])
                    3'd0: if (wBe[0]) nMsip[k] = wData[0];
                    3'd2: nCmp[k][31:0]  = mergeBytes(mCmp[k][31:0], wData, wBe);
                    3'd3: nCmp[k][63:32] = mergeBytes(mCmp[k][63:32], wData, wBe);
                    3'd4: begin
                        // A written low word never carries into the high word.
                        t[63:32] = mMtime[k][63:32];
                        t[31:0]  = mergeBytes(t[31:0], wData, wBe);
                    end
                    3'd5: t[63:32] = mergeBytes(t[63:32], wData, wBe);
                    default: ;
                endcase
            end
            nMtime[k] = t;
        end
        if (rdPulse) begin
            if (k == 0) expQ0.push_back(exp);
            else        expQ1.push_back(exp);
        end
    endtask

    task automatic checkOutput();
        compare("mtime_div1", mtime1, mMtime[0]);
        compare("mtime_div4", mtime4, mMtime[1]);
        compare("irq_div1", {61'h0, irq1}, {61'h0, mIrq[0]});
        compare("irq_div4", {61'h0, irq4}, {61'h0, mIrq[1]});
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] wa, input logic [31:0] wd,
                                 input logic [3:0] be, input logic pulse, input logic [31:0] ra,
                                 input logic ext);
        @(negedge clk);
        rst = r; wAddr = wa; wData = wd; wBe = be; rdPulse = pulse; rAddr = ra; extIrq = ext;
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            mMtime[k] = nMtime[k]; mCmp[k] = nCmp[k]; mMsip[k] = nMsip[k];
            mPre[k]   = nPre[k];   mSnap[k] = nSnap[k]; mIrq[k] = nIrq[k];
        end
        checkOutput();
    endtask

    task automatic idle(input int n, input logic ext);
        repeat (n) applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, ext);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        applyStimulus(1'b0, a, d, be, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic load(input logic [31:0] a);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, 1'b0);
    endtask

    // Compare one instance's load response against the oldest queued expectation.
    task automatic checkResponse(input int k, input logic valid, input logic [31:0] data);
        logic [32:0] e;
        if (k == 0 ? expQ0.size() != 0 : expQ1.size() != 0) begin
            e = (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
            compare(k == 0 ? "rd_div1" : "rd_div4", {31'h0, valid, data}, {31'h0, e});
        end else begin
            compare(k == 0 ? "spurious_valid_div1" : "spurious_valid_div4", {63'h0, valid}, 64'h0);
        end
    endtask

    // Monitor: samples the read port after every edge, independent of the driver.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (monitorOn) begin
                checkResponse(0, rdValid1, rdData1);
                checkResponse(1, rdValid4, rdData4);
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  be;
        logic        doWr, doRd, r, ext;
        int          guard;

        rst = 1'b1; wAddr = 32'h0; wData = 32'h0; wBe = 4'h0; rdPulse = 1'b0; rAddr = 32'h0; extIrq = 1'b0;
        applyStimulus(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        monitorOn = 1'b1;
        repeat (2) applyStimulus(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);

        $display("[TB] reset and free-running count");
        idle(10, 1'b0);
        compare("mtime_after10", mtime1, 64'd10);
        compare("irq_after10", {61'h0, irq1}, 64'h0);
        compare("valid_after10", {63'h0, rdValid1}, 64'h0);
        idle(30, 1'b0);
        compare("mtime_div4_after40", mtime4, 64'd10);
        compare("mtime_div1_after40", mtime1, 64'd40);

        $display("[TB] mtimecmp compare");
        store(BASE + 32'h0C, 32'h0, 4'hF);
        store(BASE + 32'h08, 32'h20, 4'hF);
        idle(3, 1'b0);
        compare("mtip_high", {63'h0, irq1[1]}, 64'h1);
        store(BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
        idle(2, 1'b0);
        compare("mtip_low", {63'h0, irq1[1]}, 64'h0);

        $display("[TB] tear-free mtime read");
        store(BASE + 32'h14, 32'h0, 4'hF);
        store(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
        idle(3, 1'b0);
        compare("mtime_before_lo_read", mtime1, 64'h1_0000_0002);
        load(BASE + 32'h10);
        store(BASE + 32'h14, 32'h55, 4'hF);
        load(BASE + 32'h18);
        load(BASE + 32'h14);

        $display("[TB] msip and decode");
        store(BASE + 32'h00, 32'h1, 4'b0001);
        load(BASE + 32'h00);
        load(BASE + 32'h1C);
        load(BASE + 32'h40);
        load(BASE + 32'h03);
        compare("msip_irq", {63'h0, irq1[0]}, 64'h1);
        idle(2, 1'b1);
        compare("meip_irq", {63'h0, irq1[2]}, 64'h1);
        idle(1, 1'b0);

        $display("[TB] store to mtime on a prescaler tick");
        guard = 0;
        while (mPre[1] != 3 && guard < 8) begin
            idle(1, 1'b0);
            guard++;
        end
        store(BASE + 32'h10, 32'h0000_1234, 4'hF);
        compare("mtime_div4_store_on_tick", {32'h0, mtime4[31:0]}, 64'h1234);

        $display("[TB] reset in the middle of a read");
        store(BASE + 32'h0C, 32'h0, 4'hF);
        store(BASE + 32'h08, 32'h0, 4'hF);
        idle(2, 1'b0);
        load(BASE + 32'h10);
        applyStimulus(1'b1, 32'h0, 32'h0, 4'h0, 1'b1, BASE + 32'h10, 1'b1);
        compare("rst_mtime", mtime1, 64'h0);
        compare("rst_irq", {61'h0, irq1}, 64'h0);
        compare("rst_valid", {63'h0, rdValid1}, 64'h0);
        compare("rst_data", {32'h0, rdData1}, 64'h0);

        $display("[TB] randomized traffic");
        ext = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            r    = ($urandom_range(0, 199) == 0);
            doWr = ($urandom_range(0, 2) == 0);
            doRd = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 15) == 0) ext = ~ext;
            a = BASE + {$urandom_range(0, 7), 2'b00} + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = a + 32'h20 * $urandom_range(1, 4);
            d  = $urandom;
            be = doWr ? 4'($urandom_range(0, 15)) : 4'h0;
            if (a[4:2] == 3'd2 && $urandom_range(0, 1) == 0) d = mMtime[0][31:0] + $urandom_range(0, 40);
            if (a[4:2] == 3'd3 && $urandom_range(0, 1) == 0) d = mMtime[0][63:32];
            if (a[4:2] == 3'd4 && $urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            applyStimulus(r, a, d, be, doRd,
                          BASE + {$urandom_range(0, 7), 2'b00} + 32'($urandom_range(0, 1) * 32'h40),
                          ext);
        end

        idle(2, 1'b0);
        #5;
        compare("pending_responses_div1", 64'(expQ0.size()), 64'h0);
        compare("pending_responses_div4", 64'(expQ1.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
